pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised, clocked program-counter register for the MIPS fetch stage; replaces the unclocked PC latch.
- Selects the next PC from sequential increment, branch, jump or exception vector, with fixed priority.
- Supports stall hold, halt/resume control and a fetch-valid qualifier.
- Sits between the next-PC logic and the instruction memory address port.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded by Reset
EXC_VECTOR, 32'h0000_0080, PC value loaded on Exception
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, low PC bits forced to zero on every load

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hold PC; suppresses sequential increment only
BranchTaken  in  1  load BranchTarget
BranchTarget  in  WIDTH  branch destination
Jump  in  1  load JumpTarget
JumpTarget  in  WIDTH  jump destination
Exception  in  1  load EXC_VECTOR
Halt  in  1  enter HALT state
Resume  in  1  leave HALT state
Output  out  WIDTH  current PC
NextSeq  out  WIDTH  Output+STEP, combinational, wraps modulo 2^WIDTH
Valid  out  1  Output is a fetchable address this cycle
AlignErr  out  1  sticky; set when a loaded target has nonzero low ALIGN_BITS

Behaviour:
- Reset (synchronous, active-high) is sampled on the rising edge of Clock.
  - Output=RESET_VECTOR, state=BOOT, Valid=0, AlignErr=0.
  - Reset overrides every other input, including mid-halt and mid-redirect.
- States:
  - BOOT: one bubble cycle, Output unchanged, Valid=0; always moves to RUN next cycle. An Exception during BOOT loads EXC_VECTOR and moves to RUN.
  - RUN: Valid=1. Next PC is chosen by priority:
    - Exception -> EXC_VECTOR
    - Jump -> JumpTarget
    - BranchTaken -> BranchTarget
    - Stall -> hold
    - otherwise -> NextSeq
  - Redirects (Exception, Jump, BranchTaken) take effect even while Stall=1.
  - Halt in RUN (with no Exception) -> HALT; Output holds and any simultaneous Jump/Branch is discarded.
  - HALT: Valid=0, Output holds.
    - Resume -> RUN with Output unchanged.
    - Exception -> load EXC_VECTOR and go to RUN (Exception beats Halt/Resume).
    - Halt and Resume both high -> stay in HALT.
- Target alignment:
  - Loaded targets have their low ALIGN_BITS forced to 0.
  - If the raw target had any nonzero low ALIGN_BITS, AlignErr is set and stays set until Reset.
- Latency: a redirect asserted in cycle N appears on Output in cycle N+1.
- Wrap-around: NextSeq from 2^WIDTH-STEP is 0; no flag is raised.
- State encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2. The unused code 2'd3 recovers to BOOT on the next edge.

Optional Feature:
- Macro: PC_UNIT_EPC_EN.
- When defined:
  - Adds output EPC [WIDTH-1:0], reset to 0.
  - On an accepted Exception, EPC captures the Output value of that cycle.
  - Adds input EpcRestore. In RUN with no Exception, EpcRestore loads EPC into the PC with priority just below Exception.
- When undefined: no EPC register and no EpcRestore port; behaviour is otherwise identical.

Decomposition:
- Shared header pc_defs.vh holds:
  - state encodings (PC_BOOT, PC_RUN, PC_HALT);
  - the default vectors;
  - STEP and ALIGN_BITS defaults.
- Sub-module pc_next_mux: purely combinational priority selector and alignment masker. It outputs the next PC and a misalign flag.
- pc_unit holds the state register, PC register, AlignErr and the optional EPC.

Test Plan:
- Reset then 4 idle cycles -> Output 0x0, 0x0 (BOOT, Valid=0), then 0x4, 0x8 with Valid=1.
- PC=0x10, BranchTaken=1, BranchTarget=0x200, Stall=1 -> next Output=0x200. With Stall alone, PC holds at 0x200 for 3 cycles.
- PC=0x40, Jump=1 to 0x1000, BranchTaken=1 to 0x2000, Exception=1 in the same cycle -> Output=0x80. With Exception=0 -> Output=0x1000.
- Jump to 0x123 -> Output=0x120 and AlignErr=1; AlignErr stays high until Reset, then clears to 0.
- Halt at PC=0x20 -> Valid=0 and Output=0x20 for 5 cycles; Resume -> Valid=1 and Output 0x20 then 0x24. Reset asserted while halted -> Output=0x0, state BOOT.
- PC=32'hFFFF_FFFC with no redirect -> next Output=0x0. With PC_UNIT_EPC_EN, an Exception at 0x300 gives EPC=0x300, and EpcRestore returns the PC to 0x300.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: FSM state encodings and
// default parameter values used by pc_unit and pc_next_mux.
package pc_unit_pkg;

  // BOOT=0, RUN=1, HALT=2; code 3 is unused and recovers to BOOT.
  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam int          DEF_WIDTH        = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int          DEF_STEP         = 4;
  localparam int          DEF_ALIGN_BITS   = 2;

  // True in the only state where sequential fetch and redirects apply.
  function automatic logic is_run(pc_state_e s);
    return (s == PC_RUN);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector: fixed-priority choice between exception
// vector, EPC restore, jump, branch, stall-hold and sequential increment,
// with low-bit alignment masking and a misalign flag on loaded targets.
module pc_next_mux
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP       = DEF_STEP,
  parameter int               ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             take_exc,
  input  logic             redirect_en,
  input  logic             epc_restore,
  input  logic [WIDTH-1:0] epc,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall,
  output logic [WIDTH-1:0] next_seq,
  output logic [WIDTH-1:0] next_pc,
  output logic             misalign
);

  // Mask of the low bits that every loaded address must have cleared.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  logic [WIDTH-1:0] raw_pc;
  logic             is_load;

  // Increment wraps naturally modulo 2^WIDTH.
  assign next_seq = pc + WIDTH'(STEP);

  // Priority selection; exception wins even outside RUN, other redirects only in RUN.
  always_comb begin
    raw_pc  = pc;
    is_load = 1'b0;
    if (take_exc) begin
      raw_pc  = EXC_VECTOR;
      is_load = 1'b1;
    end else if (redirect_en) begin
      if (epc_restore) begin
        raw_pc  = epc;
        is_load = 1'b1;
      end else if (jump) begin
        raw_pc  = jump_target;
        is_load = 1'b1;
      end else if (branch_taken) begin
        raw_pc  = branch_target;
        is_load = 1'b1;
      end else if (!stall) begin
        raw_pc  = next_seq;
      end
    end
  end

  assign next_pc  = is_load ? (raw_pc & ~ALIGN_MASK) : raw_pc;
  assign misalign = is_load && (|(raw_pc & ALIGN_MASK));

endmodule

// File: rtl/pc_unit.sv
// Clocked MIPS fetch-stage program counter with BOOT/RUN/HALT control,
// fetch-valid qualifier and sticky alignment error.
// Optional build macro: PC_UNIT_EPC_EN adds an exception PC register (EPC)
// and an EpcRestore input that reloads the PC from it.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP         = DEF_STEP,
  parameter int               ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Exception,
  input  logic             Halt,
  input  logic             Resume,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] NextSeq,
  output logic             Valid,
  output logic             AlignErr
`ifdef PC_UNIT_EPC_EN
  ,
  input  logic             EpcRestore,
  output logic [WIDTH-1:0] EPC
`endif
);

  pc_state_e        state_reg;
  pc_state_e        state_next;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             valid_reg;
  logic             align_err_reg;
  logic             take_exc;
  logic             redirect_en;
  logic             misalign;
  logic             epc_restore_sel;
  logic [WIDTH-1:0] epc_value;

  // An exception is accepted in every legal state; the unused code only recovers.
  assign take_exc    = Exception && (state_reg == PC_BOOT || state_reg == PC_RUN ||
                                     state_reg == PC_HALT);
  // A Halt in RUN freezes the PC and discards any simultaneous redirect.
  assign redirect_en = is_run(state_reg) && !Halt;

`ifdef PC_UNIT_EPC_EN
  logic [WIDTH-1:0] epc_reg;
  assign epc_restore_sel = EpcRestore;
  assign epc_value       = epc_reg;
  assign EPC             = epc_reg;

  // Capture the faulting PC whenever an exception is taken.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      epc_reg <= '0;
    end else if (take_exc) begin
      epc_reg <= pc_reg;
    end
  end
`else
  assign epc_restore_sel = 1'b0;
  assign epc_value       = '0;
`endif

  pc_next_mux #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_next_mux (
    .pc            (pc_reg),
    .take_exc      (take_exc),
    .redirect_en   (redirect_en),
    .epc_restore   (epc_restore_sel),
    .epc           (epc_value),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .stall         (Stall),
    .next_seq      (NextSeq),
    .next_pc       (pc_next),
    .misalign      (misalign)
  );

  // Next-state rules; Exception always returns to RUN and beats Halt/Resume.
  always_comb begin
    state_next = PC_BOOT;
    case (state_reg)
      PC_BOOT: state_next = PC_RUN;
      PC_RUN:  state_next = (!Exception && Halt) ? PC_HALT : PC_RUN;
      PC_HALT: begin
        if (Exception)            state_next = PC_RUN;
        else if (Resume && !Halt) state_next = PC_RUN;
        else                      state_next = PC_HALT;
      end
      default: state_next = PC_BOOT;
    endcase
  end

  // State, PC, registered fetch-valid and sticky alignment error.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= PC_BOOT;
      pc_reg        <= RESET_VECTOR;
      valid_reg     <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= is_run(state_next);
      if (misalign) begin
        align_err_reg <= 1'b1;
      end
    end
  end

  assign Output   = pc_reg;
  assign Valid    = valid_reg;
  assign AlignErr = align_err_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a behavioural model tracks the PC every
// cycle, plus directed literal expectations from the test plan.
module tb_pc_unit;

  localparam logic [63:0] MOD = 64'h1_0000_0000;

  logic        Clock = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, Exception, Halt, Resume;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] Output, NextSeq;
  logic        Valid, AlignErr;
`ifdef PC_UNIT_EPC_EN
  logic        EpcRestore;
  logic [31:0] EPC;
`endif

  always #5 Clock = ~Clock;

  pc_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Exception    (Exception),
    .Halt         (Halt),
    .Resume       (Resume),
    .Output       (Output),
    .NextSeq      (NextSeq),
    .Valid        (Valid),
    .AlignErr     (AlignErr)
`ifdef PC_UNIT_EPC_EN
    ,
    .EpcRestore   (EpcRestore),
    .EPC          (EPC)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arithmetic on the PC, flags for booting/halted.
  logic [63:0] m_pc, m_epc;
  bit m_boot, m_halt, m_err, m_live = 0;

  function automatic logic [63:0] aligned(input logic [63:0] t);
    return t - (t % 4);
  endfunction

  always @(posedge Clock) begin
    logic restore;
`ifdef PC_UNIT_EPC_EN
    restore = EpcRestore;
`else
    restore = 1'b0;
`endif
    if (Reset) begin
      m_pc = 0; m_epc = 0; m_boot = 1; m_halt = 0; m_err = 0; m_live = 1;
    end else if (m_live) begin
      if (Exception) begin
        m_epc = m_pc; m_pc = 64'h80; m_boot = 0; m_halt = 0;
      end else if (m_boot) begin
        m_boot = 0;
      end else if (m_halt) begin
        if (Resume && !Halt) m_halt = 0;
      end else if (Halt) begin
        m_halt = 1;
      end else if (restore) begin
        m_pc = m_epc;
      end else if (Jump) begin
        if (JumpTarget % 4 != 0) m_err = 1;
        m_pc = aligned(64'(JumpTarget));
      end else if (BranchTaken) begin
        if (BranchTarget % 4 != 0) m_err = 1;
        m_pc = aligned(64'(BranchTarget));
      end else if (!Stall) begin
        m_pc = (m_pc + 4) % MOD;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge Clock) begin
    if (m_live) begin
      chk("model_pc", 64'(Output), m_pc);
      chk("model_nextseq", 64'(NextSeq), (m_pc + 4) % MOD);
      chk("model_valid", 64'(Valid), 64'(!(m_boot || m_halt)));
      chk("model_alignerr", 64'(AlignErr), 64'(m_err));
`ifdef PC_UNIT_EPC_EN
      chk("model_epc", 64'(EPC), m_epc);
`endif
    end
  end

  task automatic clear_inputs();
    Reset = 0; Stall = 0; BranchTaken = 0; Jump = 0; Exception = 0;
    Halt = 0; Resume = 0; BranchTarget = '0; JumpTarget = '0;
`ifdef PC_UNIT_EPC_EN
    EpcRestore = 0;
`endif
  endtask

  // One clock edge with the currently driven inputs, then back to idle.
  task automatic cyc();
    @(posedge Clock);
    @(negedge Clock);
    #1;
    $display("[TB] t=%0t pc=0x%08h next=0x%08h valid=%0b alignerr=%0b",
             $time, Output, NextSeq, Valid, AlignErr);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    Reset = 1; cyc();
    chk("reset_pc", 64'(Output), 64'h0);
    chk("reset_valid", 64'(Valid), 64'h0);
    chk("reset_alignerr", 64'(AlignErr), 64'h0);
    cyc();
    chk("boot_exit_pc", 64'(Output), 64'h0);
    chk("boot_exit_valid", 64'(Valid), 64'h1);
    cyc(); chk("seq_4", 64'(Output), 64'h4);
    cyc(); chk("seq_8", 64'(Output), 64'h8);
    cyc(); cyc(); chk("seq_10", 64'(Output), 64'h10);

    // Branch while stalled, then stall hold.
    BranchTaken = 1; BranchTarget = 32'h200; Stall = 1; cyc();
    chk("branch_under_stall", 64'(Output), 64'h200);
    for (int i = 0; i < 3; i++) begin
      Stall = 1; cyc();
      chk("stall_hold", 64'(Output), 64'h200);
    end

    // Redirect priority.
    Jump = 1; JumpTarget = 32'h40; cyc();
    Jump = 1; JumpTarget = 32'h1000; BranchTaken = 1; BranchTarget = 32'h2000;
    Exception = 1; cyc();
    chk("exc_beats_all", 64'(Output), 64'h80);
    Jump = 1; JumpTarget = 32'h40; cyc();
    Jump = 1; JumpTarget = 32'h1000; BranchTaken = 1; BranchTarget = 32'h2000; cyc();
    chk("jump_beats_branch", 64'(Output), 64'h1000);
    chk("aligned_no_err", 64'(AlignErr), 64'h0);

    // Misaligned jump: masked target, sticky error.
    Jump = 1; JumpTarget = 32'h123; cyc();
    chk("misalign_pc", 64'(Output), 64'h120);
    chk("misalign_err", 64'(AlignErr), 64'h1);
    cyc(); cyc();
    chk("misalign_sticky", 64'(AlignErr), 64'h1);

    // Halt with a discarded jump, hold, Halt+Resume stays, then Resume.
    Jump = 1; JumpTarget = 32'h20; cyc();
    Halt = 1; Jump = 1; JumpTarget = 32'h500; cyc();
    chk("halt_pc", 64'(Output), 64'h20);
    chk("halt_valid", 64'(Valid), 64'h0);
    repeat (5) cyc();
    chk("halt_hold_pc", 64'(Output), 64'h20);
    Halt = 1; Resume = 1; cyc();
    chk("halt_resume_both", 64'(Valid), 64'h0);
    Resume = 1; cyc();
    chk("resume_pc", 64'(Output), 64'h20);
    chk("resume_valid", 64'(Valid), 64'h1);
    cyc(); chk("resume_seq", 64'(Output), 64'h24);

    // Exception out of HALT, then Reset while halted.
    Halt = 1; cyc();
    Exception = 1; cyc();
    chk("halt_exc_pc", 64'(Output), 64'h80);
    chk("halt_exc_valid", 64'(Valid), 64'h1);
    Halt = 1; cyc();
    Reset = 1; cyc();
    chk("reset_in_halt_pc", 64'(Output), 64'h0);
    chk("reset_in_halt_valid", 64'(Valid), 64'h0);
    chk("reset_clears_err", 64'(AlignErr), 64'h0);

    // Exception during BOOT.
    Exception = 1; cyc();
    chk("boot_exc_pc", 64'(Output), 64'h80);
    chk("boot_exc_valid", 64'(Valid), 64'h1);

    // Wrap-around.
    Jump = 1; JumpTarget = 32'hFFFF_FFFC; cyc();
    chk("wrap_nextseq", 64'(NextSeq), 64'h0);
    cyc();
    chk("wrap_pc", 64'(Output), 64'h0);
    chk("wrap_no_err", 64'(AlignErr), 64'h0);

`ifdef PC_UNIT_EPC_EN
    Jump = 1; JumpTarget = 32'h300; cyc();
    Exception = 1; cyc();
    chk("epc_capture", 64'(EPC), 64'h300);
    cyc();
    EpcRestore = 1; cyc();
    chk("epc_restore", 64'(Output), 64'h300);
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
